fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, buffer entry layout, instruction size.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Instruction buffer. FIFO of fetch entries with wrap-around
//                pointers carrying an extra MSB to tell full from empty.
//                Flush empties the buffer in one cycle. The head output reads
//                zero while the buffer is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot at the same edge, so a full buffer still
  // accepts a push when it is popped in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage contents; flush overrides push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[AW-1:0]] = data_i;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Buffer state registers; reset clears pointers and storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Sequential instruction fetch with a small instruction buffer,
//                halt and redirect. Instruction memory read is combinational;
//                the consumer sees only buffered (registered) entries.
//  Options     : FETCH_MISALIGN_CHECK_EN - when defined, a redirect to a
//                non-word-aligned target raises fault_o and stops fetching
//                until reset or an aligned redirect. When undefined, the low
//                two target bits are forced to zero and fault_o is absent.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        halt_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fault_o,
`endif
  output logic [31:0] instr_pc_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_pc;
  logic         fetch_blocked;
  logic         buf_full;
  logic         buf_empty;
  logic         push;
  logic         pop;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign target_pc     = redirect_pc_i;
  assign fetch_blocked = fault_q;
  assign fault_o       = fault_q;

  // Fault is sampled on every redirect and otherwise sticky.
  always_comb begin
    fault_d = fault_q;
    if (redirect_i) begin
      fault_d = |redirect_pc_i[1:0];
    end
  end

  // Fault flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign target_pc     = redirect_pc_i & ~32'h0000_0003;
  assign fetch_blocked = 1'b0;
`endif

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !buf_empty;
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;

  assign pop  = instr_valid_o && instr_ready_i && !redirect_i;
  assign push = (state_q == RUN) && !halt_i && !redirect_i && !fetch_blocked &&
                (!buf_full || pop);

  assign push_entry.pc    = pc_q;
  assign push_entry.instr = imem_instr_i;

  // Next PC and FSM state; redirect wins over sequential advance.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (redirect_i) begin
      pc_d = target_pc;
    end else if (push) begin
      pc_d = pc_q + 32'(INSTR_BYTES);
    end
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_i)  state_d = HALTED;
      HALTED:  if (!halt_i) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= RESET_PC;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (redirect_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Instruction
//                memory model returns word index k for byte address 4k.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] ipc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fault;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem_addr >> 2;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_addr_o   (imem_addr),
    .imem_instr_i  (imem_instr),
    .halt_i        (halt),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fault_o       (fault),
`endif
    .instr_pc_o    (ipc)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ready = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    checks++;
    if ({valid, instr, ipc, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_outputs: got v=%0b i=%h pc=%h a=%h want 0", valid, instr, ipc, imem_addr);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %0b want 0", fault); end
`endif
    rst_n = 1'b1;
    cyc();
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL boot_cycle_valid: got %0b want 0", valid); end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL first_entry: got v=%0b pc=%h i=%h want 1/0/0", valid, ipc, instr);
    end
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] epc, ein;
      epc = 32'(4 * k); ein = 32'(k);
      cyc();
      checks++;
      if ({valid, ipc, instr} !== {1'b1, epc, ein}) begin
        failures++;
        $display("FAIL stream_%0d: got v=%0b pc=%h i=%h want 1/%h/%h", k, valid, ipc, instr, epc, ein);
      end
    end
  endtask

  task automatic test_backpressure();
    rst_n = 1'b0; ready = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    checks++;
    if ({imem_addr, valid, ipc, instr} !== {32'h8, 1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL stall_hold: got a=%h v=%0b pc=%h i=%h want 8/1/0/0", imem_addr, valid, ipc, instr);
    end
    ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      logic [31:0] epc, ein;
      epc = 32'(4 * j); ein = 32'(j);
      cyc();
      checks++;
      if ({valid, ipc, instr} !== {1'b1, epc, ein}) begin
        failures++;
        $display("FAIL stall_release_%0d: got v=%0b pc=%h i=%h want 1/%h/%h", j, valid, ipc, instr, epc, ein);
      end
    end
  endtask

  task automatic test_redirect_full();
    ready = 1'b0;
    cyc(); cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h100}) begin
      failures++;
      $display("FAIL redirect_flush: got v=%0b a=%h want 0/100", valid, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h100, 32'd64}) begin
      failures++;
      $display("FAIL redirect_target: got v=%0b pc=%h i=%h want 1/100/40", valid, ipc, instr);
    end
  endtask

  task automatic test_halt();
    cyc();
    checks++;
    if (imem_addr !== 32'h108) begin failures++; $display("FAIL halt_prefill_addr: got %h want 108", imem_addr); end
    ready = 1'b1; halt = 1'b1;
    cyc();
    checks++;
    if ({valid, ipc, instr, imem_addr} !== {1'b1, 32'h104, 32'd65, 32'h108}) begin
      failures++;
      $display("FAIL halt_drain1: got v=%0b pc=%h i=%h a=%h want 1/104/41/108", valid, ipc, instr, imem_addr);
    end
    cyc(); cyc(); cyc();
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h108}) begin
      failures++;
      $display("FAIL halt_empty: got v=%0b a=%h want 0/108", valid, imem_addr);
    end
    halt = 1'b0;
    cyc();
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL halt_exit_wait: got v=%0b want 0", valid); end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h108, 32'd66}) begin
      failures++;
      $display("FAIL halt_resume: got v=%0b pc=%h i=%h want 1/108/42", valid, ipc, instr);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      failures++;
      $display("FAIL wrap_flush: got v=%0b a=%h want 0/fffffffc", valid, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0}) begin
      failures++;
      $display("FAIL wrap_last: got v=%0b pc=%h i=%h a=%h want 1/fffffffc/3fffffff/0", valid, ipc, instr, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL wrap_zero: got v=%0b pc=%h i=%h want 1/0/0", valid, ipc, instr);
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if ({fault, valid, imem_addr} !== {1'b1, 1'b0, 32'h102}) begin
      failures++;
      $display("FAIL misalign_fault: got f=%0b v=%0b a=%h want 1/0/102", fault, valid, imem_addr);
    end
    cyc(); cyc(); cyc();
    checks++;
    if ({fault, valid, imem_addr} !== {1'b1, 1'b0, 32'h102}) begin
      failures++;
      $display("FAIL misalign_no_push: got f=%0b v=%0b a=%h want 1/0/102", fault, valid, imem_addr);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    checks++;
    if ({fault, valid, imem_addr} !== {1'b0, 1'b0, 32'h200}) begin
      failures++;
      $display("FAIL misalign_clear: got f=%0b v=%0b a=%h want 0/0/200", fault, valid, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h200, 32'd128}) begin
      failures++;
      $display("FAIL misalign_resume: got v=%0b pc=%h i=%h want 1/200/80", valid, ipc, instr);
    end
`else
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h100}) begin
      failures++;
      $display("FAIL unaligned_masked: got v=%0b a=%h want 0/100", valid, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h100, 32'd64}) begin
      failures++;
      $display("FAIL unaligned_entry: got v=%0b pc=%h i=%h want 1/100/40", valid, ipc, instr);
    end
`endif
  endtask

  task automatic test_midreset();
    cyc(); cyc();
    redirect = 1'b1; redirect_pc = 32'h300;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, instr, ipc, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL midreset_async: got v=%0b i=%h pc=%h a=%h want 0", valid, instr, ipc, imem_addr);
    end
    cyc();
    redirect = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if ({valid, imem_addr} !== {1'b0, 32'h0}) begin
      failures++;
      $display("FAIL midreset_boot: got v=%0b a=%h want 0/0", valid, imem_addr);
    end
    cyc();
    checks++;
    if ({valid, ipc, instr} !== {1'b1, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL midreset_first: got v=%0b pc=%h i=%h want 1/0/0", valid, ipc, instr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_halt();
    test_wrap();
    test_misalign();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
